// File: rtl/gpio_debounce_if.sv
// Pad-side bundle for the GPIO debouncer: raw pad inputs in, clean level and edge events out.
interface gpio_debounce_if #(
  parameter int Width = 8
);
  logic [Width-1:0] gp_raw_i;
  logic [Width-1:0] gp_o;
  logic [Width-1:0] rise_o;
  logic [Width-1:0] fall_o;
  logic             tick_o;

  modport master (output gp_raw_i, input gp_o, rise_o, fall_o, tick_o);
  modport slave  (input gp_raw_i, output gp_o, rise_o, fall_o, tick_o);
endinterface

// File: rtl/gpio_debounce.sv
// Per-bit synchroniser + tick-sampled debouncer for board switches/buttons.
// One shared prescaler drives Width small per-bit qualification counters.
module gpio_debounce_bit #(
  parameter int   StableTicks = 10,
  parameter logic ResetBit    = 1'b0
) (
  input  logic clk_sys_i,
  input  logic rst_sys_i,
  input  logic tick_i,
  input  logic sync_i,
  output logic gp_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = $clog2(StableTicks + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          gp_q, gp_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    gp_d   = gp_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    // Any cycle where the input agrees with the output restarts qualification.
    if (sync_i == gp_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CW'(StableTicks - 1)) begin
        gp_d   = sync_i;
        cnt_d  = '0;
        rise_d = sync_i;
        fall_d = ~sync_i;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      cnt_q  <= '0;
      gp_q   <= ResetBit;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gp_q   <= gp_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign gp_o   = gp_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

module gpio_debounce #(
  parameter int               Width       = 8,
  parameter int               SyncStages  = 2,
  parameter int               TickCycles  = 50000,
  parameter int               StableTicks = 10,
  parameter logic [Width-1:0] ResetValue  = '0
) (
  input  logic          clk_sys_i,
  input  logic          rst_sys_i,
  gpio_debounce_if.slave bus
);
  localparam int PW = $clog2(TickCycles);

  logic [SyncStages-1:0][Width-1:0] sync_q, sync_d;
  logic [PW-1:0]                    presc_q, presc_d;
  logic                             tick_q, tick_d;
  logic [Width-1:0]                 gp, rise, fall;

  always_comb begin
    sync_d[0] = bus.gp_raw_i;
    for (int s = 1; s < SyncStages; s++) sync_d[s] = sync_q[s-1];
    tick_d  = (presc_q == PW'(TickCycles - 1));
    presc_d = tick_d ? '0 : presc_q + PW'(1);
  end

  // Sync chain loads ResetValue too, so reset itself never looks like an edge.
  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sync_q  <= {SyncStages{ResetValue}};
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  end

  for (genvar i = 0; i < Width; i++) begin : g_bit
    gpio_debounce_bit #(
      .StableTicks (StableTicks),
      .ResetBit    (ResetValue[i])
    ) u_bit (
      .clk_sys_i (clk_sys_i),
      .rst_sys_i (rst_sys_i),
      .tick_i    (tick_q),
      .sync_i    (sync_q[SyncStages-1][i]),
      .gp_o      (gp[i]),
      .rise_o    (rise[i]),
      .fall_o    (fall[i])
    );
  end

  assign bus.gp_o   = gp;
  assign bus.rise_o = rise;
  assign bus.fall_o = fall;
  assign bus.tick_o = tick_q;
endmodule

// File: tb/tb_gpio_debounce.sv
// Directed stimulus with a pulse scoreboard: expected edge events are queued,
// a negedge monitor pops and checks them whenever rise_o/fall_o fire.
module tb_gpio_debounce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   tick_cnt = 0;

  typedef struct {
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] gp;
    int         t0;
    int         lo;
    int         hi;
    string      name;
  } exp_t;

  exp_t sb[$];

  gpio_debounce_if #(.Width(4)) bus ();

  gpio_debounce #(
    .Width(4), .SyncStages(2), .TickCycles(4), .StableTicks(3), .ResetValue(4'b0000)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_i (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input logic [3:0] r, input logic [3:0] f, input logic [3:0] g,
                              input int lo, input int hi, input string name);
    exp_t e;
    e.rise = r; e.fall = f; e.gp = g; e.t0 = cyc; e.lo = lo; e.hi = hi; e.name = name;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    tick_cnt += int'(bus.tick_o === 1'b1);
    if ((bus.rise_o | bus.fall_o) != 4'b0000) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: rise=%b fall=%b gp=%b, expected none (cycle %0d)",
                 bus.rise_o, bus.fall_o, bus.gp_o, cyc);
      end else begin
        exp_t e;
        int   d;
        e = sb.pop_front();
        d = cyc - e.t0;
        chk({e.name, "_rise"}, 32'(bus.rise_o), 32'(e.rise));
        chk({e.name, "_fall"}, 32'(bus.fall_o), 32'(e.fall));
        chk({e.name, "_gp"},   32'(bus.gp_o),   32'(e.gp));
        vectors++;
        if (d < e.lo || d > e.hi) begin
          miscompares++;
          $display("FAIL %s_latency: got %0d cycles, expected %0d..%0d", e.name, d, e.lo, e.hi);
        end
      end
    end
  end

  initial begin
    int t;
    bus.gp_raw_i = 4'hF;
    rst = 1'b1;

    // Reset with all pads high: outputs stay quiet, then one qualified rise.
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_gp",   32'(bus.gp_o),   32'h0);
      chk("rst_rise", 32'(bus.rise_o), 32'h0);
      chk("rst_fall", 32'(bus.fall_o), 32'h0);
      chk("rst_tick", 32'(bus.tick_o), 32'h0);
    end
    expect_pulse(4'hF, 4'h0, 4'hF, 9, 14, "reset_rise");
    rst = 1'b0;
    step(20);

    // Reset with pads low returns gp_o to 0 without a fall pulse.
    bus.gp_raw_i = 4'h0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(4);
    chk("clear_gp", 32'(bus.gp_o), 32'h0);

    t = tick_cnt;
    step(40);
    chk("tick_count", 32'(tick_cnt - t), 32'd10);

    // Clean step on bit 0.
    expect_pulse(4'b0001, 4'b0000, 4'b0001, 11, 14, "clean_step");
    bus.gp_raw_i[0] = 1'b1;
    step(20);

    // Bit 1 bounces every 5 cycles: never qualifies.
    for (int i = 0; i < 12; i++) begin
      bus.gp_raw_i[1] = ~bus.gp_raw_i[1];
      step(5);
    end
    step(15);
    chk("bounce_gp", 32'(bus.gp_o), 32'b0001);

    // Bit 2 bounces in 3-cycle halves, then settles high.
    for (int i = 0; i < 3; i++) begin
      bus.gp_raw_i[2] = 1'b1;
      step(3);
      bus.gp_raw_i[2] = 1'b0;
      step(3);
    end
    expect_pulse(4'b0100, 4'b0000, 4'b0101, 9, 14, "settle");
    bus.gp_raw_i[2] = 1'b1;
    step(20);

    // Opposite changes on all bits in one cycle.
    chk("pre_simul_gp", 32'(bus.gp_o), 32'b0101);
    expect_pulse(4'b1010, 4'b0101, 4'b1010, 11, 14, "simul");
    bus.gp_raw_i = 4'b1010;
    step(20);

    expect_pulse(4'b0000, 4'b1010, 4'b0000, 11, 14, "all_low");
    bus.gp_raw_i = 4'b0000;
    step(20);

    // Reset mid-qualification on bit 3: pending change is dropped, requalified afresh.
    bus.gp_raw_i[3] = 1'b1;
    step(6);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_pulse(4'b1000, 4'b0000, 4'b1000, 9, 14, "midreset");
    step(20);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
